intpol2_d4_ctrl: RTL and testbench

Sequencing controller for the D=4 quadratic-interpolation squared-term datapath (`intpol2_D4_squared`). Each frame it accepts `n_samples` input samples over a valid/ready handshake and emits four output beats per sample. It drives the datapath's `clear`, `en_xi2` and `sel_xi2` so the xi2 accumulator is loaded, primed and stepped in lock-step with the handshakes. It sits between the sample source / sink and the interpolator datapath, one instance per interpolator.

---
 rtl/intpol2_d4_ctrl.sv | 152 +++++++++++++++
 tb/tb_intpol2_d4_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/intpol2_d4_ctrl.sv
// intpol2_d4_ctrl: sequencing controller for the D=4 quadratic-interpolation
// squared-term datapath. Accepts n samples per frame and emits four phase beats
// per sample. It steers the xi2 accumulator (clear / load / scale / step) in
// lock-step with the input and output handshakes.
module intpol2_d4_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           phase_o,
  output logic [CNT_WIDTH-1:0] sample_idx_o,
  output logic                 clear_o,
  output logic                 en_xi2_o,
  output logic [1:0]           sel_xi2_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    WAIT_IN = 3'd2,
    PRIME   = 3'd3,
    EMIT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_SCALE = 2'b10;
  localparam logic [1:0] SEL_STEP  = 2'b11;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] sample_idx_q, sample_idx_d;
  logic [1:0]           phase_q, phase_d;
  logic                 abort_q, abort_d;
  logic                 en_d;
  logic [1:0]           sel_d;
  logic                 last_sample;

  // The final sample of the frame is the one whose index equals the latched count minus one.
  assign last_sample = (sample_idx_q == (n_q - CNT_WIDTH'(1)));

  // State and counter registers; reset drops back to IDLE and abandons any frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      n_q          <= '0;
      sample_idx_q <= '0;
      phase_q      <= 2'd0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      sample_idx_q <= sample_idx_d;
      phase_q      <= phase_d;
      abort_q      <= abort_d;
    end
  end

  // Next-state logic plus the handshake-gated datapath enable/select; abort overrides any handshake.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    sample_idx_d = sample_idx_q;
    phase_d      = phase_q;
    abort_d      = abort_q;
    en_d         = 1'b0;
    sel_d        = SEL_IDLE;

    if ((state_q != IDLE) && abort_i) begin
      state_d = CLR;
      abort_d = 1'b1;
      phase_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_d          = n_samples_i;
            sample_idx_d = '0;
            phase_d      = 2'd0;
            abort_d      = 1'b0;
            state_d      = (n_samples_i == '0) ? DONE : CLR;
          end
        end
        CLR: begin
          state_d = abort_q ? IDLE : WAIT_IN;
          abort_d = 1'b0;
        end
        WAIT_IN: begin
          if (in_valid_i) begin
            en_d = 1'b1;
            if (sample_idx_q == '0) begin
              sel_d   = SEL_LOAD;
              state_d = PRIME;
            end else begin
              sel_d   = SEL_STEP;
              state_d = EMIT;
            end
          end
        end
        PRIME: begin
          en_d    = 1'b1;
          sel_d   = SEL_SCALE;
          state_d = EMIT;
        end
        EMIT: begin
          if (out_ready_i) begin
            if (phase_q != 2'd3) begin
              en_d    = 1'b1;
              sel_d   = SEL_STEP;
              phase_d = phase_q + 2'd1;
            end else begin
              phase_d = 2'd0;
              if (last_sample) begin
                state_d = DONE;
              end else begin
                sample_idx_d = sample_idx_q + CNT_WIDTH'(1);
                state_d      = WAIT_IN;
              end
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = (state_q == WAIT_IN);
  assign out_valid_o  = (state_q == EMIT);
  assign clear_o      = (state_q == CLR);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign phase_o      = phase_q;
  assign sample_idx_o = sample_idx_q;
  assign en_xi2_o     = en_d;
  assign sel_xi2_o    = sel_d;

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// tb_intpol2_d4_ctrl: directed self-checking bench for the interpolation
// sequencing controller. Each frame is driven cycle by cycle and the
// observed handshakes, enables and selects are condensed into counters and
// packed sequences, then compared against hand-derived values.
module tb_intpol2_d4_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         abort;
  logic [W-1:0] n_samples;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   phase;
  logic [W-1:0] sample_idx;
  logic         clear;
  logic         en_xi2;
  logic [1:0]   sel_xi2;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  int          enCount, beatCount, ovCount, stallEn, doneCount, doneCycle;
  int          clearCount, inReadyCount, firstInReady, firstOutValid;
  int          abortEn, abortPhase, abortIdx, lastIdx;
  logic [31:0] selSeq, phaseSeq, idxSeq;
  logic [63:0] busyTrace;

  intpol2_d4_ctrl #(.CNT_WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start),
    .abort_i      (abort),
    .n_samples_i  (n_samples),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .phase_o      (phase),
    .sample_idx_o (sample_idx),
    .clear_o      (clear),
    .en_xi2_o     (en_xi2),
    .sel_xi2_o    (sel_xi2),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic ab, input logic iv, input logic ordy,
                               input logic [W-1:0] n);
    @(posedge clk);
    #1;
    start     = s;
    abort     = ab;
    in_valid  = iv;
    out_ready = ordy;
    n_samples = n;
    @(negedge clk);
  endtask

  function automatic logic [31:0] packedOutputs();
    return 32'({in_ready, out_valid, phase, sample_idx, clear, en_xi2, sel_xi2, busy, done});
  endfunction

  task automatic runFrame(input logic [W-1:0] n, input bit toggle, input int abortK,
                          input int restartK, input int cycles);
    enCount = 0; beatCount = 0; ovCount = 0; stallEn = 0; doneCount = 0; doneCycle = -1;
    clearCount = 0; inReadyCount = 0; firstInReady = -1; firstOutValid = -1;
    abortEn = -1; abortPhase = -1; abortIdx = -1; lastIdx = -1;
    selSeq = '0; phaseSeq = '0; idxSeq = '0; busyTrace = '0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, n);
    busyTrace[0] = busy;
    for (int k = 1; k <= cycles; k++) begin
      applyStimulus(k == restartK, k == abortK, 1'b1, toggle ? k[0] : 1'b1,
                    (k == restartK) ? W'(7) : n);
      if (en_xi2) begin
        enCount++;
        selSeq = {selSeq[29:0], sel_xi2};
      end
      if (k == abortK) begin
        abortEn    = int'(en_xi2);
        abortPhase = int'(phase);
        abortIdx   = int'(sample_idx);
      end
      if (out_valid) begin
        ovCount++;
        if (firstOutValid < 0) firstOutValid = k;
      end
      if (out_valid && out_ready) begin
        beatCount++;
        phaseSeq = {phaseSeq[29:0], phase};
        idxSeq   = {idxSeq[29:0], sample_idx[1:0]};
      end
      if (en_xi2 && out_valid && !out_ready) stallEn++;
      if (done) begin
        doneCount++;
        doneCycle = k;
      end
      if (clear) clearCount++;
      if (in_ready) begin
        inReadyCount++;
        if (firstInReady < 0) firstInReady = k;
      end
      busyTrace[k] = busy;
      lastIdx = int'(sample_idx);
    end
  endtask

  initial begin
    int idleBad;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; n_samples = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", packedOutputs(), 32'h0);
    rstn = 1'b1;

    $display("[TB] n=1, always ready");
    runFrame(W'(1), 1'b0, -1, -1, 12);
    checkOutput("n1_sel_seq", selSeq, 32'h1BF);
    checkOutput("n1_en_count", enCount, 5);
    checkOutput("n1_beats", beatCount, 4);
    checkOutput("n1_phase_seq", phaseSeq, 32'h1B);
    checkOutput("n1_first_in_ready", firstInReady, 2);
    checkOutput("n1_first_out_valid", firstOutValid, 4);
    checkOutput("n1_clear_count", clearCount, 1);
    checkOutput("n1_done_cycle", doneCycle, 8);
    checkOutput("n1_done_count", doneCount, 1);
    checkOutput("n1_busy_at_start", 32'(busyTrace[0]), 0);
    checkOutput("n1_busy_at_done", 32'(busyTrace[8]), 1);
    checkOutput("n1_busy_after_done", 32'(busyTrace[9]), 0);

    $display("[TB] n=3, always ready");
    runFrame(W'(3), 1'b0, -1, -1, 22);
    checkOutput("n3_beats", beatCount, 12);
    checkOutput("n3_en_count", enCount, 13);
    checkOutput("n3_sel_seq", selSeq, 32'h1BFFFFF);
    checkOutput("n3_phase_seq", phaseSeq, 32'h1B1B1B);
    checkOutput("n3_idx_seq", idxSeq, 32'h0055AA);
    checkOutput("n3_done_cycle", doneCycle, 18);
    checkOutput("n3_idx_hold", lastIdx, 2);

    $display("[TB] n=2, out_ready toggling");
    runFrame(W'(2), 1'b1, -1, -1, 24);
    checkOutput("n2t_beats", beatCount, 8);
    checkOutput("n2t_phase_seq", phaseSeq, 32'h1B1B);
    checkOutput("n2t_stall_en", stallEn, 0);
    checkOutput("n2t_en_count", enCount, 9);
    checkOutput("n2t_ov_cycles", ovCount, 15);
    checkOutput("n2t_done_cycle", doneCycle, 20);

    $display("[TB] n=0");
    runFrame(W'(0), 1'b0, -1, -1, 4);
    checkOutput("n0_done_cycle", doneCycle, 1);
    checkOutput("n0_clear_count", clearCount, 0);
    checkOutput("n0_in_ready_count", inReadyCount, 0);
    checkOutput("n0_busy_after_done", 32'(busyTrace[2]), 0);

    $display("[TB] n=4, abort at phase 2 of sample 1");
    runFrame(W'(4), 1'b0, 11, -1, 16);
    checkOutput("abort_phase", abortPhase, 2);
    checkOutput("abort_idx", abortIdx, 1);
    checkOutput("abort_en", abortEn, 0);
    checkOutput("abort_en_count", enCount, 8);
    checkOutput("abort_clear_count", clearCount, 2);
    checkOutput("abort_busy_in_clr", 32'(busyTrace[12]), 1);
    checkOutput("abort_busy_idle", 32'(busyTrace[13]), 0);
    checkOutput("abort_no_done", doneCount, 0);

    $display("[TB] n=1 after abort");
    runFrame(W'(1), 1'b0, -1, -1, 12);
    checkOutput("post_abort_done_cycle", doneCycle, 8);
    checkOutput("post_abort_sel_seq", selSeq, 32'h1BF);

    $display("[TB] n=2 with start while busy");
    runFrame(W'(2), 1'b0, -1, 5, 16);
    checkOutput("busy_start_done_cycle", doneCycle, 13);
    checkOutput("busy_start_beats", beatCount, 8);
    checkOutput("busy_start_done_count", doneCount, 1);

    $display("[TB] reset during EMIT");
    runFrame(W'(2), 1'b0, -1, -1, 5);
    checkOutput("pre_reset_out_valid", 32'(out_valid), 1);
    rstn = 1'b0;
    #1;
    checkOutput("mid_reset_outputs", packedOutputs(), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idleBad = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, W'(2));
      if (busy || done || out_valid) idleBad++;
    end
    checkOutput("post_reset_idle", idleBad, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
